// File: rtl/apb_capture_pkg.sv
// Shared definitions for the APB capture bank: register map, control/status
// bit positions, trigger mode encoding and the CTRL register layout.
package apb_capture_pkg;

   // Register addresses (8-bit map, truncated to the APB address width at use)
   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h01;
   localparam logic [7:0] ADDR_COUNT  = 8'h02;
   localparam logic [7:0] ADDR_MATCH  = 8'h03;
   localparam logic [7:0] ADDR_MASK   = 8'h04;
   localparam logic [7:0] ADDR_POP    = 8'h05;
   localparam logic [7:0] ADDR_LIVE   = 8'h08;

   // CTRL bit positions
   localparam int unsigned CTRL_EN        = 0;
   localparam int unsigned CTRL_MODE      = 1;
   localparam int unsigned CTRL_ONESHOT   = 2;
   localparam int unsigned CTRL_IRQEN     = 3;
   localparam int unsigned CTRL_CHSEL_LSB = 4;
   localparam int unsigned CTRL_CHSEL_W   = 3;
   localparam int unsigned CTRL_FLUSH     = 7;

   // STATUS bit positions
   localparam int unsigned STAT_EMPTY = 0;
   localparam int unsigned STAT_FULL  = 1;
   localparam int unsigned STAT_OVF   = 2;

   localparam logic [7:0] MASK_RESET = 8'hFF;

   typedef enum logic {
      MODE_CHANGE = 1'b0,
      MODE_MATCH  = 1'b1
   } mode_e;

   // Stored CTRL bits [6:0]; FLUSH is an action strobe and is never stored.
   typedef struct packed {
      logic [CTRL_CHSEL_W-1:0] chsel;
      logic                    irqen;
      logic                    oneshot;
      mode_e                   mode;
      logic                    en;
   } ctrl_t;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous sample FIFO with wrap-around pointers.
// Ports: clk, rst_n (async active-low), flush (empties, beats push),
//        push/din, pop/dout (head, valid when !empty), full, empty, level.
module capture_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW:0]  wr_ptr;
   logic [PW:0]  rd_ptr;
   logic         push_ok;
   logic         pop_ok;

   // Status decoded from the extra pointer MSB
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign level = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[PW-1:0]];

   // A pop frees the slot this same edge, so push while full succeeds with it
   assign pop_ok  = pop & ~empty & ~flush;
   assign push_ok = push & ~flush & (~full | pop_ok);

   // Pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // Storage, no reset needed: contents are only visible through valid pointers
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/apb_capture_bank.sv
// Multi-channel input capture bank on an 8-bit APB slave.
// Synchronises CH channels of W bits, detects change/match events on the
// selected channel and queues samples in a DEPTH-entry FIFO.
// Ports: PCLK, PRESETn (async active-low), APB slave (PSEL, PENABLE, PWRITE,
//        PADDR, PWDATA, PRDATA, PREADY, PSLVERR), INREG raw inputs, IRQ.
module apb_capture_bank
   import apb_capture_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned CH    = 2,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 5
) (
   input  logic            PCLK,
   input  logic            PRESETn,
   input  logic            PSEL,
   input  logic            PENABLE,
   input  logic            PWRITE,
   input  logic [AW-1:0]   PADDR,
   input  logic [7:0]      PWDATA,
   output logic [7:0]      PRDATA,
   output logic            PREADY,
   output logic            PSLVERR,
   input  logic [CH*W-1:0] INREG,
   output logic            IRQ
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic [CH*W-1:0] s0;
   logic [CH*W-1:0] s1;
   logic [W-1:0]    prev;
   logic [W-1:0]    sel_val;
   logic [W-1:0]    live_val;
   logic [W-1:0]    mask_w;
   logic [W-1:0]    match_w;
   ctrl_t           ctrl;
   logic [7:0]      match_r;
   logic [7:0]      mask_r;
   logic            ovf;
   logic            suppress;

   logic            access;
   logic [AW-1:0]   live_off;
   logic            live_hit;
   logic [7:0]      rdata;
   logic            err;
   logic            ctrl_we;
   logic            status_we;
   logic            match_we;
   logic            mask_we;
   logic            pop;
   logic            flush;

   logic            hit_now;
   logic            hit_prev;
   logic            trig;
   logic            push;
   logic            push_ok;

   logic [W-1:0]    head;
   logic            full;
   logic            empty;
   logic [LW-1:0]   level;

   assign access   = PSEL & PENABLE;
   assign live_off = PADDR - AW'(ADDR_LIVE);
   assign live_hit = (PADDR >= AW'(ADDR_LIVE)) && (32'(live_off) < CH);
   assign mask_w   = mask_r[W-1:0];
   assign match_w  = match_r[W-1:0];

   // Channel muxes for the trigger path and for LIVE reads
   always_comb begin
      sel_val  = '0;
      live_val = '0;
      for (int unsigned c = 0; c < CH; c++) begin
         if (32'(ctrl.chsel) == c) sel_val  = s1[c*W +: W];
         if (32'(live_off) == c)   live_val = s1[c*W +: W];
      end
   end

   // APB decode: read mux, write strobes and error response
   always_comb begin
      rdata     = '0;
      err       = 1'b0;
      ctrl_we   = 1'b0;
      status_we = 1'b0;
      match_we  = 1'b0;
      mask_we   = 1'b0;
      pop       = 1'b0;
      if (access) begin
         if (PADDR == AW'(ADDR_CTRL)) begin
            if (!PWRITE) rdata = {1'b0, ctrl};
            else if (32'(PWDATA[CTRL_CHSEL_LSB +: CTRL_CHSEL_W]) >= CH) err = 1'b1;
            else ctrl_we = 1'b1;
         end else if (PADDR == AW'(ADDR_STATUS)) begin
            if (PWRITE) status_we = 1'b1;
            else        rdata = 8'({ovf, full, empty});
         end else if (PADDR == AW'(ADDR_COUNT)) begin
            if (PWRITE) err = 1'b1;
            else        rdata = 8'(level);
         end else if (PADDR == AW'(ADDR_MATCH)) begin
            if (PWRITE) match_we = 1'b1;
            else        rdata = match_r;
         end else if (PADDR == AW'(ADDR_MASK)) begin
            if (PWRITE) mask_we = 1'b1;
            else        rdata = mask_r;
         end else if (PADDR == AW'(ADDR_POP)) begin
            if (PWRITE || empty) err = 1'b1;
            else begin
               rdata = 8'(head);
               pop   = 1'b1;
            end
         end else if (live_hit && !PWRITE) begin
            rdata = 8'(live_val);
         end else begin
            err = 1'b1;
         end
      end
   end

   assign PRDATA  = rdata;
   assign PSLVERR = err;
   assign PREADY  = 1'b1;
   assign flush   = ctrl_we & PWDATA[CTRL_FLUSH];

   // Trigger: masked change, or rising edge of masked match
   always_comb begin
      hit_now  = ((sel_val & mask_w) == (match_w & mask_w));
      hit_prev = ((prev & mask_w) == (match_w & mask_w));
      if (ctrl.mode == MODE_MATCH) trig = hit_now & ~hit_prev;
      else                         trig = |((sel_val ^ prev) & mask_w);
   end

   // suppress covers the cycle where prev still holds the old channel
   assign push    = trig & ctrl.en & ~suppress;
   assign push_ok = push & ~flush & (~full | pop);

   capture_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (sel_val),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Synchronisers, trigger history and register file
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         s0       <= '0;
         s1       <= '0;
         prev     <= '0;
         suppress <= 1'b0;
         ctrl     <= '0;
         match_r  <= '0;
         mask_r   <= MASK_RESET;
         ovf      <= 1'b0;
         IRQ      <= 1'b0;
      end else begin
         s0       <= INREG;
         s1       <= s0;
         prev     <= sel_val;
         suppress <= ctrl_we;
         IRQ      <= ctrl.irqen & ~empty;

         // A CTRL write overrides a one-shot disarm on the same edge
         if (ctrl_we)                     ctrl    <= ctrl_t'(PWDATA[6:0]);
         else if (push_ok & ctrl.oneshot) ctrl.en <= 1'b0;

         if (match_we) match_r <= PWDATA;
         if (mask_we)  mask_r  <= PWDATA;

         // Overflow set wins over a same-edge W1C; flush always clears
         if (push & ~flush & full & ~pop)                    ovf <= 1'b1;
         else if (flush | (status_we & PWDATA[STAT_OVF]))    ovf <= 1'b0;
      end
   end

endmodule
